timer_bus_slave: RTL and testbench
==================================

TIMER_BUS_SLAVE -- requirements
Module: timer_bus_slave

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter P_WAIT_STATES SHALL default to 1 and sets the number of wait cycles before gnt, with a legal range of 0..2.
REQ-003 Widths P_ADDR_WIDTH and P_DATA_WIDTH SHALL come from design_params_pkg, with P_DATA_WIDTH ≥ 16.
REQ-004 Port `clk`: input, 1 bit, rising-edge clock.
REQ-005 Port `rst`: input, 1 bit, synchronous active-high reset.
REQ-006 Port `req`: input, 1 bit, master request.
REQ-007 Port `addr`: input, P_ADDR_WIDTH bits, register word address.
REQ-008 Port `wdata`: input, P_DATA_WIDTH bits, write data.
REQ-009 Port `write_en`: input, 1 bit; 1 = write, 0 = read.
REQ-010 Port `gnt`: output, 1 bit, one-cycle grant / transfer completion.
REQ-011 Port `rdata`: output, P_DATA_WIDTH bits, read data, valid only while gnt=1.
REQ-012 Port `irq`: output, 1 bit, level interrupt.

Function
REQ-013 The responder FSM SHALL have states IDLE, WAIT and GRANT.
- IDLE: req=1 sampled → capture addr/wdata/write_en; go to WAIT if P_WAIT_STATES>0, else to GRANT.
- WAIT: counts P_WAIT_STATES cycles, then goes to GRANT.
- GRANT: gnt=1 for exactly one cycle, then IDLE.
REQ-014 gnt SHALL assert P_WAIT_STATES+1 cycles after the edge sampling req (worst case 3), and SHALL be registered (never combinational from req).
REQ-015 gnt SHALL deassert the cycle after GRANT, regardless of req.
REQ-016 If req is still high in IDLE after a grant, it SHALL be treated as a new request.
REQ-017 req dropping during WAIT SHALL NOT abort the transaction; the captured transaction completes.
REQ-018 Register map, on exact full-width address match:
- 0 CTRL (RW): bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
- 1 LOAD (RW).
- 2 COUNT (RO).
- 3 STATUS: bit0 EXPIRED, write-1-to-clear.
REQ-019 Writes SHALL commit at the clock edge ending the GRANT cycle.
REQ-020 Read data SHALL be the register value during the GRANT cycle; rdata SHALL be 0 outside GRANT.
REQ-021 Unmapped addresses SHALL read 0, ignore writes, and still receive gnt.
REQ-022 Writing LOAD SHALL also copy wdata into COUNT on the same edge, overriding any decrement that cycle.
REQ-023 COUNT update per cycle:
- EN=1 and COUNT>0: COUNT decrements by 1; on the 1→0 transition EXPIRED is set.
- EN=1, COUNT=0, AUTO_RELOAD=1: COUNT←LOAD.
- EN=1, COUNT=0, AUTO_RELOAD=0: COUNT holds.
- EN=0: COUNT holds.
REQ-024 COUNT arithmetic SHALL be unsigned P_DATA_WIDTH with no underflow below 0.
REQ-025 If the EXPIRED set condition and a W1C of EXPIRED occur on the same edge, set SHALL win.
REQ-026 irq SHALL be a registered copy of EXPIRED & IRQ_EN, lagging by one cycle.
REQ-027 Writes to COUNT or to read-only bits SHALL be ignored.

Reset
REQ-028 While rst=1, on every rising edge: FSM←IDLE, gnt=0, rdata=0, irq=0, and CTRL, LOAD, COUNT and STATUS all ←0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no gnt and no register commit.
REQ-030 The first request SHALL be sampled on the first edge with rst=0.

Structure
REQ-031 The register address constants and the FSM state enum SHALL reside in design_params_pkg.
REQ-032 The down-counter with reload and expiry flag SHALL be a sub-module, timer_counter; the bus FSM and register decode SHALL remain in timer_bus_slave.

Verification
REQ-033 Scenario — grant timing, P_WAIT_STATES=1:
- Stimulus: read addr 1 after reset.
- Response: gnt high exactly 2 cycles after req is sampled, for 1 cycle; rdata=0.
REQ-034 Scenario — one-shot expiry:
- Stimulus: write LOAD=5, then CTRL=0x5.
- Response: COUNT reads 5,4,…,0; EXPIRED=1 on the 1→0 edge; irq=1 one cycle later; COUNT holds at 0.
REQ-035 Scenario — auto-reload:
- Stimulus: LOAD=3, CTRL=0x3.
- Response: COUNT sequence 3,2,1,0,3,2,…; EXPIRED set on each 1→0 transition.
REQ-036 Scenario — W1C collision:
- Stimulus: W1C STATUS=0x1 committed on the same edge COUNT goes 1→0.
- Response: EXPIRED remains 1; a later W1C clears it and irq drops the next cycle.
REQ-037 Scenario — unmapped access:
- Stimulus: write then read addr 7 with wdata=0xA5A5.
- Response: gnt given for both; rdata=0; no register changes.
REQ-038 Scenario — reset mid-transaction:
- Stimulus: rst asserted during WAIT of a write to LOAD=9.
- Response: no gnt; LOAD=0 after reset; the next request is granted normally.
REQ-039 Sweep P_WAIT_STATES=0 and 2: gnt latency SHALL be 1 and 3 cycles respectively, and gnt SHALL never be high for two consecutive cycles.

Source files
------------

// File: rtl/design_params_pkg.sv
// Shared parameters for the timer bus responder.
//   P_ADDR_WIDTH / P_DATA_WIDTH : bus address and data widths (data >= 16 bits)
//   ADDR_*                      : register word addresses, matched on the full width
//   state_e                     : bus responder FSM states
package design_params_pkg;

  localparam int P_ADDR_WIDTH = 8;
  localparam int P_DATA_WIDTH = 16;

  localparam logic [P_ADDR_WIDTH-1:0] ADDR_CTRL   = P_ADDR_WIDTH'(0);
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_LOAD   = P_ADDR_WIDTH'(1);
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_COUNT  = P_ADDR_WIDTH'(2);
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_STATUS = P_ADDR_WIDTH'(3);

  // CTRL bit positions
  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

endpackage

// File: rtl/timer_counter.sv
// Down-counter with reload and sticky expiry flag.
//   clk, rst        : clock, synchronous active-high reset
//   en_i            : count enable
//   auto_reload_i   : reload from reload_val_i when enabled and at zero
//   reload_val_i    : reload value (LOAD register)
//   load_we_i       : direct load of load_data_i, overrides any decrement
//   load_data_i     : value for a direct load
//   clr_expired_i   : clear request for the expiry flag (loses to a new expiry)
//   count_o         : current count
//   expired_o       : sticky expiry flag, set on a 1->0 decrement
module timer_counter
  import design_params_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    auto_reload_i,
  input  logic [P_DATA_WIDTH-1:0] reload_val_i,
  input  logic                    load_we_i,
  input  logic [P_DATA_WIDTH-1:0] load_data_i,
  input  logic                    clr_expired_i,
  output logic [P_DATA_WIDTH-1:0] count_o,
  output logic                    expired_o
);

  logic [P_DATA_WIDTH-1:0] count_q, count_d;
  logic                    expired_q, expired_d;
  logic                    expire_s;

  // Next count: direct load wins, otherwise decrement / reload / hold.
  always_comb begin
    count_d  = count_q;
    expire_s = 1'b0;
    if (load_we_i) begin
      count_d = load_data_i;
    end else if (en_i) begin
      if (count_q != {P_DATA_WIDTH{1'b0}}) begin
        count_d  = count_q - P_DATA_WIDTH'(1);
        expire_s = (count_q == P_DATA_WIDTH'(1));
      end else if (auto_reload_i) begin
        count_d = reload_val_i;
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Expiry flag: a new expiry beats a simultaneous clear.
  always_comb begin
    if (expire_s) begin
      expired_d = 1'b1;
    end else if (clr_expired_i) begin
      expired_d = 1'b0;
    end else begin
      expired_d = expired_q;
    end
  end

  // Counter and flag state.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= {P_DATA_WIDTH{1'b0}};
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = expired_q;

endmodule

// File: rtl/timer_bus_slave.sv
// Bus responder with a timer register block.
//   clk, rst  : clock, synchronous active-high reset
//   req       : master request, sampled in IDLE
//   addr      : register word address (full-width match)
//   wdata     : write data
//   write_en  : 1 = write, 0 = read
//   gnt       : one-cycle grant, P_WAIT_STATES+1 cycles after the sampling edge
//   rdata     : read data, zero outside the grant cycle
//   irq       : level interrupt, EXPIRED & IRQ_EN delayed one cycle
module timer_bus_slave
  import design_params_pkg::*;
#(
  parameter int P_WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic [P_ADDR_WIDTH-1:0] addr,
  input  logic [P_DATA_WIDTH-1:0] wdata,
  input  logic                    write_en,
  output logic                    gnt,
  output logic [P_DATA_WIDTH-1:0] rdata,
  output logic                    irq
);

  state_e                  state_q, state_d;
  logic [1:0]              wait_cnt_q, wait_cnt_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [P_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    gnt_q;
  logic [2:0]              ctrl_q, ctrl_d;
  logic [P_DATA_WIDTH-1:0] load_q, load_d;
  logic                    irq_q, irq_d;

  logic                    wr_commit_s;
  logic                    ctrl_we_s, load_we_s, status_clr_s;
  logic [P_DATA_WIDTH-1:0] count_s;
  logic                    expired_s;
  logic [P_DATA_WIDTH-1:0] rdata_s;

  // Responder FSM; the transaction is captured in IDLE so later req/addr changes do not matter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d     = addr;
          wdata_d    = wdata;
          we_d       = write_en;
          wait_cnt_d = 2'd0;
          state_d    = (P_WAIT_STATES > 0) ? ST_WAIT : ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q >= 2'(P_WAIT_STATES - 1)) begin
          state_d = ST_GRANT;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      ST_GRANT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Register write decode; writes land on the edge that ends the grant cycle.
  always_comb begin
    wr_commit_s  = gnt_q & we_q;
    ctrl_we_s    = 1'b0;
    load_we_s    = 1'b0;
    status_clr_s = 1'b0;
    case (addr_q)
      ADDR_CTRL:   ctrl_we_s    = wr_commit_s;
      ADDR_LOAD:   load_we_s    = wr_commit_s;
      ADDR_STATUS: status_clr_s = wr_commit_s & wdata_q[0];
      default:     ctrl_we_s    = 1'b0;
    endcase
    if (ctrl_we_s) begin
      ctrl_d = wdata_q[2:0];
    end else begin
      ctrl_d = ctrl_q;
    end
    if (load_we_s) begin
      load_d = wdata_q;
    end else begin
      load_d = load_q;
    end
    irq_d = expired_s & ctrl_q[CTRL_IRQ_EN];
  end

  // Read mux, only driven during the grant cycle.
  always_comb begin
    rdata_s = {P_DATA_WIDTH{1'b0}};
    if (gnt_q) begin
      case (addr_q)
        ADDR_CTRL:   rdata_s = {{(P_DATA_WIDTH-3){1'b0}}, ctrl_q};
        ADDR_LOAD:   rdata_s = load_q;
        ADDR_COUNT:  rdata_s = count_s;
        ADDR_STATUS: rdata_s = {{(P_DATA_WIDTH-1){1'b0}}, expired_s};
        default:     rdata_s = {P_DATA_WIDTH{1'b0}};
      endcase
    end else begin
      rdata_s = {P_DATA_WIDTH{1'b0}};
    end
  end

  // State, captured transaction, grant and register flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 2'd0;
      addr_q     <= {P_ADDR_WIDTH{1'b0}};
      wdata_q    <= {P_DATA_WIDTH{1'b0}};
      we_q       <= 1'b0;
      gnt_q      <= 1'b0;
      ctrl_q     <= 3'd0;
      load_q     <= {P_DATA_WIDTH{1'b0}};
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      gnt_q      <= (state_d == ST_GRANT);
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      irq_q      <= irq_d;
    end
  end

  timer_counter u_counter (
    .clk           (clk),
    .rst           (rst),
    .en_i          (ctrl_q[CTRL_EN]),
    .auto_reload_i (ctrl_q[CTRL_AUTO_RELOAD]),
    .reload_val_i  (load_q),
    .load_we_i     (load_we_s),
    .load_data_i   (wdata_q),
    .clr_expired_i (status_clr_s),
    .count_o       (count_s),
    .expired_o     (expired_s)
  );

  assign gnt   = gnt_q;
  assign rdata = rdata_s;
  assign irq   = irq_q;

endmodule

// File: tb/tb_timer_bus_slave.sv
// Self-checking bench: random and directed bus traffic against a cycle-level
// reference of the register/timer rules; extra instances check other wait-state settings.
module tb_timer_bus_slave;
  import design_params_pkg::*;

  localparam int AW = P_ADDR_WIDTH;
  localparam int DW = P_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          req, req0, req2;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          write_en;
  logic          gnt, gnt0, gnt2;
  logic [DW-1:0] rdata, rdata0, rdata2;
  logic          irq, irq0, irq2;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [2:0]    m_ctrl;
  logic [DW-1:0] m_load, m_count;
  logic          m_exp, m_irq;

  always #5 clk = ~clk;

  timer_bus_slave #(.P_WAIT_STATES(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata),
    .write_en(write_en), .gnt(gnt), .rdata(rdata), .irq(irq));

  timer_bus_slave #(.P_WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .req(req0), .addr(addr), .wdata(wdata),
    .write_en(write_en), .gnt(gnt0), .rdata(rdata0), .irq(irq0));

  timer_bus_slave #(.P_WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .req(req2), .addr(addr), .wdata(wdata),
    .write_en(write_en), .gnt(gnt2), .rdata(rdata2), .irq(irq2));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == AW'(0))      return {{(DW-3){1'b0}}, m_ctrl};
    else if (a == AW'(1)) return m_load;
    else if (a == AW'(2)) return m_count;
    else if (a == AW'(3)) return {{(DW-1){1'b0}}, m_exp};
    else                  return {DW{1'b0}};
  endfunction

  task automatic model_reset();
    m_ctrl = 3'd0; m_load = '0; m_count = '0; m_exp = 1'b0; m_irq = 1'b0;
  endtask

  // One clock edge of the timer rules, with an optional committed write.
  task automatic model_edge(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] n_count;
    logic          set_exp;
    m_irq   = m_exp & m_ctrl[2];
    n_count = m_count;
    set_exp = 1'b0;
    if (wr && a == AW'(1)) n_count = d;
    else if (m_ctrl[0]) begin
      if (m_count > 0) begin
        n_count = m_count - 1'b1;
        set_exp = (m_count == 1);
      end else if (m_ctrl[1]) n_count = m_load;
    end
    if (set_exp) m_exp = 1'b1;
    else if (wr && a == AW'(3) && d[0]) m_exp = 1'b0;
    m_count = n_count;
    if (wr && a == AW'(0)) m_ctrl = d[2:0];
    if (wr && a == AW'(1)) m_load = d;
  endtask

  task automatic tick(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(wr, a, d);
    #1;
    check_eq("irq", irq, m_irq);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req = 1'b0;
      tick(1'b0, '0, '0);
      check_eq("gnt_idle", gnt, 0);
      check_eq("rdata_idle", rdata, 0);
    end
  endtask

  // One bus transaction on the one-wait-state instance.
  task automatic xact(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit rnd, output logic [DW-1:0] rd);
    req = 1'b1; addr = a; wdata = d; write_en = wr;
    tick(1'b0, '0, '0);                       // sampling edge
    check_eq("gnt_wait", gnt, 0);
    check_eq("rdata_wait", rdata, 0);
    if (rnd) begin
      req = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom); write_en = 1'($urandom);
    end else req = 1'b0;
    tick(1'b0, '0, '0);                       // enters grant
    check_eq("gnt", gnt, 1);
    if (!wr) check_eq("rdata", rdata, m_read(a));
    rd = rdata;
    req = rnd ? 1'($urandom) : 1'b0;
    tick(wr, a, d);                           // write commits here
    check_eq("gnt_drop", gnt, 0);
  endtask

  // Latency and no-back-to-back-grant check for the 0 / 2 wait-state instances.
  task automatic sweep(input int ws);
    int  lat;
    bit  prev, g;
    lat = 0; prev = 1'b0;
    req = 1'b0; addr = AW'(1); write_en = 1'b0;
    if (ws == 0) req0 = 1'b1; else req2 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0, '0, '0);
      g = (ws == 0) ? gnt0 : gnt2;
      if (g && lat == 0) lat = k;
      check_eq("gnt_consec", {31'd0, g & prev}, 0);
      prev = g;
    end
    check_eq(ws == 0 ? "lat_ws0" : "lat_ws2", lat, ws + 1);
    req0 = 1'b0; req2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, '0, '0);
      g = (ws == 0) ? gnt0 : gnt2;
      check_eq("gnt_consec_tail", {31'd0, g & prev}, 0);
      prev = g;
    end
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [AW-1:0] ra;
    logic [DW-1:0] rdat;
    bit            rw;

    rst = 1'b1; req = 1'b0; req0 = 1'b0; req2 = 1'b0;
    addr = '0; wdata = '0; write_en = 1'b0;
    model_reset();
    tick(1'b0, '0, '0);
    tick(1'b0, '0, '0);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_rdata", rdata, 0);
    rst = 1'b0;

    // first request on the first edge out of reset
    xact(1'b0, AW'(1), '0, 1'b0, rd);
    check_eq("first_read", rd, 0);

    // one-shot expiry
    xact(1'b1, AW'(1), DW'(5), 1'b0, rd);
    xact(1'b1, AW'(0), DW'(5), 1'b0, rd);
    for (int i = 0; i < 3; i++) xact(1'b0, AW'(2), '0, 1'b0, rd);
    idle(3);
    xact(1'b0, AW'(2), '0, 1'b0, rd);
    check_eq("oneshot_count", rd, 0);
    xact(1'b0, AW'(3), '0, 1'b0, rd);
    check_eq("oneshot_expired", rd, 1);

    // auto-reload
    xact(1'b1, AW'(0), DW'(0), 1'b0, rd);
    xact(1'b1, AW'(3), DW'(1), 1'b0, rd);
    xact(1'b1, AW'(1), DW'(3), 1'b0, rd);
    xact(1'b1, AW'(0), DW'(3), 1'b0, rd);
    for (int i = 0; i < 6; i++) begin
      xact(1'b0, AW'(2), '0, 1'b0, rd);
      idle(i % 2);
    end

    // W1C colliding with the 1->0 edge
    xact(1'b1, AW'(0), DW'(0), 1'b0, rd);
    xact(1'b1, AW'(3), DW'(1), 1'b0, rd);
    xact(1'b1, AW'(1), DW'(3), 1'b0, rd);
    xact(1'b1, AW'(0), DW'(5), 1'b0, rd);
    xact(1'b1, AW'(3), DW'(1), 1'b0, rd);
    xact(1'b0, AW'(3), '0, 1'b0, rd);
    check_eq("w1c_collision", rd, 1);
    xact(1'b1, AW'(3), DW'(1), 1'b0, rd);
    xact(1'b0, AW'(3), '0, 1'b0, rd);
    check_eq("w1c_clear", rd, 0);
    idle(2);

    // unmapped access
    xact(1'b1, AW'(7), DW'(16'hA5A5), 1'b0, rd);
    xact(1'b0, AW'(7), '0, 1'b0, rd);
    check_eq("unmapped_read", rd, 0);
    xact(1'b0, AW'(1), '0, 1'b0, rd);
    xact(1'b0, AW'(0), '0, 1'b0, rd);

    // reset during the wait cycle of a LOAD write
    req = 1'b1; addr = AW'(1); wdata = DW'(9); write_en = 1'b1;
    tick(1'b0, '0, '0);
    check_eq("abort_wait_gnt", gnt, 0);
    rst = 1'b1; req = 1'b0;
    tick(1'b0, '0, '0);
    check_eq("abort_rst_gnt", gnt, 0);
    tick(1'b0, '0, '0);
    rst = 1'b0;
    idle(2);
    xact(1'b0, AW'(1), '0, 1'b0, rd);
    check_eq("abort_load", rd, 0);

    // other wait-state settings
    sweep(0);
    sweep(2);

    // random traffic
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    ra = AW'(0);
        2, 3:    ra = AW'(1);
        4:       ra = AW'(2);
        5, 6:    ra = AW'(3);
        7:       ra = AW'($urandom_range(4, 7));
        default: ra = AW'($urandom);
      endcase
      rw   = 1'($urandom);
      rdat = (ra == AW'(1)) ? DW'($urandom_range(0, 10)) : DW'($urandom);
      xact(rw, ra, rdat, 1'b1, rd);
      idle($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
